// File: rtl/i2c_seq_pkg.sv
// ---------------------------------------------------------------------------
// i2c_seq_pkg : shared types and field layout for the I2C command sequencer
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package i2c_seq_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ISSUE     = 3'd1,
    WAIT_BUSY = 3'd2,
    WAIT_DONE = 3'd3,
    RESP      = 3'd4
  } state_t;

  localparam int CMD_W = 16;
  localparam int RSP_W = 9;

  // Command entry layout: {addr[6:0], rw, wdata[7:0]}
  function automatic logic [CMD_W-1:0] pack_cmd(input logic [6:0] addr,
                                                input logic       rw,
                                                input logic [7:0] wdata);
    return {addr, rw, wdata};
  endfunction

endpackage

`default_nettype wire

// File: rtl/i2c_cmd_sequencer_sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo : single-clock FIFO with show-ahead head and occupancy count
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_rdata,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int            AW     = $clog2(DEPTH);
  localparam logic [AW:0]   c_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == c_FULL);
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_rdata = r_mem[r_rptr];

  // A full FIFO refuses pushes even when a pop happens in the same cycle
  assign w_push = i_push && !o_full;
  assign w_pop  = i_pop  && !o_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= i_wdata;
        r_wptr        <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/i2c_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// i2c_cmd_sequencer : queues host I2C commands, issues them one at a time to
// the bridge and returns one in-order response per command. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module i2c_cmd_sequencer
  import i2c_seq_pkg::*;
#(
  parameter int CMD_DEPTH = 4,
  parameter int RSP_DEPTH = 4,
  parameter int TIMEOUT   = 4095,
  parameter int CNT_W     = $clog2(TIMEOUT + 1)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_cmd_valid,
  output logic                         o_cmd_ready,
  input  logic [6:0]                   i_cmd_addr,
  input  logic                         i_cmd_rw,
  input  logic [7:0]                   i_cmd_wdata,
  output logic                         o_rsp_valid,
  input  logic                         i_rsp_ready,
  output logic [7:0]                   o_rsp_data,
  output logic                         o_rsp_err,
  output logic                         o_i2c_enable,
  output logic [6:0]                   o_i2c_addr,
  output logic                         o_i2c_rw,
  output logic [7:0]                   o_i2c_data_in,
  input  logic [7:0]                   i_i2c_data_out,
  input  logic                         i_i2c_ready,
  output logic                         o_busy,
  output logic [$clog2(CMD_DEPTH):0]   o_cmd_count
);

  localparam logic [CNT_W-1:0] c_TIMEOUT = CNT_W'(TIMEOUT);

  state_t                       r_state;
  logic [CNT_W-1:0]             r_cnt;
  logic                         r_enable;
  logic [6:0]                   r_addr;
  logic                         r_rw;
  logic [7:0]                   r_wdata;
  logic [7:0]                   r_rsp_data;
  logic                         r_rsp_err;

  logic [CMD_W-1:0]             w_cmd_head;
  logic                         w_cmd_full;
  logic                         w_cmd_empty;
  logic [RSP_W-1:0]             w_rsp_head;
  logic                         w_rsp_full;
  logic                         w_rsp_empty;
  logic [$clog2(RSP_DEPTH):0]   w_rsp_cnt_unused;
  logic                         w_issue;
  logic                         w_rsp_push;
  logic                         w_timeout;

  // Issue only when a response slot is already free, so RESP can never stall
  assign w_issue    = (r_state == IDLE) && !w_cmd_empty && i_i2c_ready && !w_rsp_full;
  assign w_rsp_push = (r_state == RESP);
  assign w_timeout  = (r_cnt == c_TIMEOUT);

  sync_fifo #(.WIDTH(CMD_W), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (i_cmd_valid),
    .i_wdata (pack_cmd(i_cmd_addr, i_cmd_rw, i_cmd_wdata)),
    .i_pop   (w_issue),
    .o_rdata (w_cmd_head),
    .o_full  (w_cmd_full),
    .o_empty (w_cmd_empty),
    .o_count (o_cmd_count)
  );

  sync_fifo #(.WIDTH(RSP_W), .DEPTH(RSP_DEPTH)) u_rsp_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_rsp_push),
    .i_wdata ({r_rsp_data, r_rsp_err}),
    .i_pop   (i_rsp_ready),
    .o_rdata (w_rsp_head),
    .o_full  (w_rsp_full),
    .o_empty (w_rsp_empty),
    .o_count (w_rsp_cnt_unused)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_enable   <= 1'b0;
      r_addr     <= '0;
      r_rw       <= 1'b0;
      r_wdata    <= '0;
      r_rsp_data <= '0;
      r_rsp_err  <= 1'b0;
    end else begin
      r_enable <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_issue) begin
            r_addr   <= w_cmd_head[15:9];
            r_rw     <= w_cmd_head[8];
            r_wdata  <= w_cmd_head[7:0];
            r_enable <= 1'b1;
            r_state  <= ISSUE;
          end
        end
        ISSUE: begin
          r_cnt   <= '0;
          r_state <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (!i_i2c_ready) begin
            r_cnt   <= '0;
            r_state <= WAIT_DONE;
          end else if (w_timeout) begin
            r_rsp_data <= '0;
            r_rsp_err  <= 1'b1;
            r_state    <= RESP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        WAIT_DONE: begin
          if (i_i2c_ready) begin
            r_rsp_data <= r_rw ? i_i2c_data_out : 8'h00;
            r_rsp_err  <= 1'b0;
            r_state    <= RESP;
          end else if (w_timeout) begin
            r_rsp_data <= '0;
            r_rsp_err  <= 1'b1;
            r_state    <= RESP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        RESP: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign o_cmd_ready   = !w_cmd_full;
  assign o_rsp_valid   = !w_rsp_empty;
  assign o_rsp_data    = w_rsp_head[8:1];
  assign o_rsp_err     = w_rsp_head[0];
  assign o_i2c_enable  = r_enable;
  assign o_i2c_addr    = r_addr;
  assign o_i2c_rw      = r_rw;
  assign o_i2c_data_in = r_wdata;
  assign o_busy        = (r_state != IDLE) || !w_cmd_empty;

endmodule

`default_nettype wire

// File: tb/tb_i2c_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// tb_i2c_cmd_sequencer : directed self-checking bench with a simple bridge model
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_i2c_cmd_sequencer;

  localparam int TO = 100;

  logic       clk;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [6:0] cmd_addr;
  logic       cmd_rw;
  logic [7:0] cmd_wdata;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_data;
  logic       rsp_err;
  logic       i2c_enable;
  logic [6:0] i2c_addr;
  logic       i2c_rw;
  logic [7:0] i2c_data_in;
  logic [7:0] i2c_data_out;
  logic       i2c_ready;
  logic       busy;
  logic [2:0] cmd_count;

  int checks = 0;
  int errors = 0;
  int en_count = 0;
  int max_cmd_count = 0;
  int model_hang = 0;
  logic [7:0] model_q[$];
  logic saw_not_ready = 1'b0;

  i2c_cmd_sequencer #(.CMD_DEPTH(4), .RSP_DEPTH(4), .TIMEOUT(TO)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_cmd_valid    (cmd_valid),
    .o_cmd_ready    (cmd_ready),
    .i_cmd_addr     (cmd_addr),
    .i_cmd_rw       (cmd_rw),
    .i_cmd_wdata    (cmd_wdata),
    .o_rsp_valid    (rsp_valid),
    .i_rsp_ready    (rsp_ready),
    .o_rsp_data     (rsp_data),
    .o_rsp_err      (rsp_err),
    .o_i2c_enable   (i2c_enable),
    .o_i2c_addr     (i2c_addr),
    .o_i2c_rw       (i2c_rw),
    .o_i2c_data_in  (i2c_data_in),
    .i_i2c_data_out (i2c_data_out),
    .i_i2c_ready    (i2c_ready),
    .o_busy         (busy),
    .o_cmd_count    (cmd_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (i2c_enable) en_count++;
    if (int'(cmd_count) > max_cmd_count) max_cmd_count = int'(cmd_count);
  end

  // Bridge model: ready drops 3 cycles after enable, returns 40 cycles later
  initial begin
    i2c_ready    = 1'b1;
    i2c_data_out = 8'hEE;
    forever begin
      @(posedge clk); #3;
      if (i2c_enable) begin
        if (model_hang != 0) begin
          model_hang = 0;
        end else begin
          repeat (3) begin @(posedge clk); #3; end
          i2c_ready = 1'b0;
          repeat (40) begin @(posedge clk); #3; end
          i2c_data_out = (model_q.size() > 0) ? model_q.pop_front() : 8'hEE;
          i2c_ready    = 1'b1;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at a negedge with cmd_valid low
  task automatic push_cmd(input logic [6:0] a, input logic rw, input logic [7:0] d);
    int n = 0;
    cmd_valid = 1'b1; cmd_addr = a; cmd_rw = rw; cmd_wdata = d;
    while (!cmd_ready && n < 2000) begin
      saw_not_ready = 1'b1;
      @(negedge clk); n++;
    end
    if (!cmd_ready) check("push_wait", {31'd0, cmd_ready}, 32'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic pop_rsp(input string tag, input logic [7:0] d, input logic e);
    int n = 0;
    while (!rsp_valid && n < TO * 4) begin @(negedge clk); n++; end
    check({tag, "_valid"}, {31'd0, rsp_valid}, 32'd1);
    check({tag, "_data"}, {24'd0, rsp_data}, {24'd0, d});
    check({tag, "_err"}, {31'd0, rsp_err}, {31'd0, e});
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic wait_enable(input string tag);
    int n = 0;
    while (!i2c_enable && n < 200) begin @(negedge clk); n++; end
    check({tag, "_en"}, {31'd0, i2c_enable}, 32'd1);
  endtask

  task automatic wait_ready(input logic lvl);
    int n = 0;
    while (i2c_ready !== lvl && n < 200) begin @(negedge clk); n++; end
    check("bridge_ready_wait", {31'd0, i2c_ready}, {31'd0, lvl});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0;
    int n;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_addr = '0; cmd_rw = 1'b0; cmd_wdata = '0;
    rsp_ready = 1'b0;
    repeat (3) @(negedge clk);

    check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_rsp_data", {24'd0, rsp_data}, 32'd0);
    check("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
    check("rst_enable", {31'd0, i2c_enable}, 32'd0);
    check("rst_addr", {25'd0, i2c_addr}, 32'd0);
    check("rst_rw", {31'd0, i2c_rw}, 32'd0);
    check("rst_data_in", {24'd0, i2c_data_in}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_cmd_count", {29'd0, cmd_count}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single write: bridge data is 0xEE but a write must return 0
    e0 = en_count;
    push_cmd(7'h2A, 1'b0, 8'h5C);
    wait_enable("wr");
    check("wr_addr", {25'd0, i2c_addr}, 32'h2A);
    check("wr_rw", {31'd0, i2c_rw}, 32'd0);
    check("wr_data_in", {24'd0, i2c_data_in}, 32'h5C);
    @(negedge clk);
    check("wr_en_pulse", {31'd0, i2c_enable}, 32'd0);
    pop_rsp("wr", 8'h00, 1'b0);
    check("wr_en_count", en_count - e0, 32'd1);

    // Read with exact ready-rise to rsp_valid latency
    model_q.push_back(8'hA7);
    push_cmd(7'h10, 1'b1, 8'h00);
    wait_ready(1'b0);
    wait_ready(1'b1);
    check("rd_lat0", {31'd0, rsp_valid}, 32'd0);
    @(negedge clk);
    check("rd_lat1", {31'd0, rsp_valid}, 32'd0);
    @(negedge clk);
    check("rd_lat2", {31'd0, rsp_valid}, 32'd1);
    check("rd_addr_held", {25'd0, i2c_addr}, 32'h10);
    pop_rsp("rd", 8'hA7, 1'b0);

    // Timeout: first enable is ignored by the bridge, second completes
    e0 = en_count;
    model_hang = 1;
    model_q.push_back(8'h99);
    push_cmd(7'h20, 1'b1, 8'h00);
    push_cmd(7'h21, 1'b1, 8'h00);
    wait_enable("to");
    n = 0;
    while (!rsp_valid && n < TO * 3) begin @(negedge clk); n++; end
    check("to_latency", {31'd0, n >= TO}, 32'd1);
    pop_rsp("to", 8'h00, 1'b1);
    pop_rsp("to_next", 8'h99, 1'b0);
    check("to_en_count", en_count - e0, 32'd2);

    // Backpressure: responses held, 6 reads queued
    e0 = en_count;
    max_cmd_count = 0;
    saw_not_ready = 1'b0;
    for (int i = 1; i <= 6; i++) model_q.push_back(8'(i));
    for (int i = 1; i <= 6; i++) push_cmd(7'(7'h30 + i), 1'b1, 8'h00);
    n = 0;
    while (en_count - e0 < 4 && n < 1000) begin @(negedge clk); n++; end
    repeat (60) @(negedge clk);
    check("bp_saw_not_ready", {31'd0, saw_not_ready}, 32'd1);
    check("bp_max_count", max_cmd_count, 32'd4);
    check("bp_en_stalled", en_count - e0, 32'd4);
    check("bp_cmd_left", {29'd0, cmd_count}, 32'd2);
    check("bp_busy", {31'd0, busy}, 32'd1);
    for (int i = 1; i <= 6; i++) pop_rsp("bp", 8'(i), 1'b0);
    check("bp_en_total", en_count - e0, 32'd6);

    // Simultaneous response pop and command push
    push_cmd(7'h44, 1'b0, 8'h12);
    n = 0;
    while ((!rsp_valid || busy) && n < 200) begin @(negedge clk); n++; end
    check("sim_pre_data", {24'd0, rsp_data}, 32'd0);
    check("sim_pre_busy", {31'd0, busy}, 32'd0);
    model_q.push_back(8'h3C);
    rsp_ready = 1'b1;
    cmd_valid = 1'b1; cmd_addr = 7'h55; cmd_rw = 1'b1; cmd_wdata = 8'h00;
    @(negedge clk);
    rsp_ready = 1'b0;
    cmd_valid = 1'b0;
    check("sim_popped", {31'd0, rsp_valid}, 32'd0);
    check("sim_cmd_count", {29'd0, cmd_count}, 32'd1);
    check("sim_busy", {31'd0, busy}, 32'd1);
    wait_enable("sim");
    check("sim_addr", {25'd0, i2c_addr}, 32'h55);
    check("sim_cmd_empty", {29'd0, cmd_count}, 32'd0);
    pop_rsp("sim", 8'h3C, 1'b0);

    // Reset during WAIT_DONE with two commands queued
    push_cmd(7'h11, 1'b0, 8'hA1);
    push_cmd(7'h12, 1'b0, 8'hA2);
    push_cmd(7'h13, 1'b0, 8'hA3);
    wait_ready(1'b0);
    repeat (5) @(negedge clk);
    check("mr_pre_count", {29'd0, cmd_count}, 32'd2);
    #1 rst_n = 1'b0;
    #1;
    check("mr_cmd_count", {29'd0, cmd_count}, 32'd0);
    check("mr_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("mr_enable", {31'd0, i2c_enable}, 32'd0);
    check("mr_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    e0 = en_count;
    wait_ready(1'b1);
    repeat (20) @(negedge clk);
    check("mr_no_enable", en_count - e0, 32'd0);
    check("mr_no_rsp", {31'd0, rsp_valid}, 32'd0);
    check("mr_idle", {31'd0, busy}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
